// File: rtl/spi_defines_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_defines_pkg
// Description : Shared SPI constants and the TX arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package spi_defines_pkg;

    localparam int ARB_NUM_REQ        = 4;
    localparam int ARB_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_POP     = 3'd1,
        ARB_CAPTURE = 3'd2,
        ARB_START   = 3'd3,
        ARB_WAIT    = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_picker
// Description : Combinational round-robin pick, scanning upward from
//               last_grant+1 and wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================

module spi_rr_picker
    import spi_defines_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int GIDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GIDW-1:0]    last_grant,
    output logic               pick_valid,
    output logic [GIDW-1:0]    pick_id
);

    logic [GIDW-1:0]      w_base;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    int                   w_off;
    int                   w_sum;

    always_comb begin
        w_base     = '0;
        w_dbl      = {req, req};
        w_rot      = '0;
        w_off      = 0;
        w_sum      = 0;
        pick_valid = |req;
        pick_id    = '0;

        if (last_grant != GIDW'(NUM_REQ - 1)) begin
            w_base = last_grant + 1'b1;
        end

        // Rotate so bit 0 is the highest-priority requester, then take the lowest set bit.
        w_rot = NUM_REQ'(w_dbl >> w_base);
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = j;
            end
        end

        w_sum = int'(w_base) + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        pick_id = GIDW'(w_sum);
    end

endmodule

`default_nettype wire

// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_arbiter
// Description : Round-robin sequencer sharing one SPI serializer among
//               NUM_REQ transmit FIFOs. Optional WAIT watchdog is enabled
//               by defining SPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module spi_tx_arbiter
    import spi_defines_pkg::*;
#(
    parameter int NUM_REQ        = ARB_NUM_REQ,
    parameter int DATAWIDTH      = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
    parameter int GIDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_empty,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_pop,
    output logic [DATAWIDTH-1:0]           ser_data,
    output logic                           ser_start,
    input  logic                           ser_done,
    output logic [GIDW-1:0]                grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("spi_tx_arbiter: parameter out of range");
    end

    arb_state_t           r_state_q, w_state_d;
    logic [NUM_REQ-1:0]   r_req_pop_q, w_req_pop_d;
    logic [DATAWIDTH-1:0] r_ser_data_q, w_ser_data_d;
    logic                 r_ser_start_q, w_ser_start_d;
    logic [GIDW-1:0]      r_grant_id_q, w_grant_id_d;
    logic [GIDW-1:0]      r_last_grant_q, w_last_grant_d;
    logic                 r_busy_q, w_busy_d;

    logic                 w_pick_valid;
    logic [GIDW-1:0]      w_pick_id;
    logic [DATAWIDTH-1:0] w_sel_data;
    logic                 w_timeout_hit;

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GIDW    (GIDW)
    ) u_picker (
        .req        (~req_empty),
        .last_grant (r_last_grant_q),
        .pick_valid (w_pick_valid),
        .pick_id    (w_pick_id)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id_q == GIDW'(i)) begin
                w_sel_data = req_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [C_CNT_W-1:0] r_wd_cnt_q, w_wd_cnt_d;
    logic               r_timeout_err_q;

    // Counter reads 0 on the first WAIT cycle; a same-cycle ser_done beats the limit.
    always_comb begin
        w_wd_cnt_d    = '0;
        w_timeout_hit = 1'b0;
        if (r_state_q == ARB_WAIT) begin
            w_wd_cnt_d    = r_wd_cnt_q + 1'b1;
            w_timeout_hit = (w_wd_cnt_d == C_CNT_W'(TIMEOUT_CYCLES)) && !ser_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt_q      <= '0;
            r_timeout_err_q <= 1'b0;
        end else begin
            r_wd_cnt_q      <= w_wd_cnt_d;
            r_timeout_err_q <= w_timeout_hit;
        end
    end

    assign timeout_err = r_timeout_err_q;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_req_pop_d    = '0;
        w_ser_data_d   = r_ser_data_q;
        w_ser_start_d  = 1'b0;
        w_grant_id_d   = r_grant_id_q;
        w_last_grant_d = r_last_grant_q;

        case (r_state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_id_d = w_pick_id;
                    w_req_pop_d  = NUM_REQ'(1) << w_pick_id;
                    w_state_d    = ARB_POP;
                end
            end
            ARB_POP: begin
                w_state_d = ARB_CAPTURE;
            end
            ARB_CAPTURE: begin
                w_ser_data_d  = w_sel_data;
                w_ser_start_d = 1'b1;
                w_state_d     = ARB_START;
            end
            ARB_START: begin
                w_state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (ser_done || w_timeout_hit) begin
                    w_last_grant_d = r_grant_id_q;
                    w_state_d      = ARB_IDLE;
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ARB_IDLE;
            r_req_pop_q    <= '0;
            r_ser_data_q   <= '0;
            r_ser_start_q  <= 1'b0;
            r_grant_id_q   <= '0;
            r_last_grant_q <= GIDW'(NUM_REQ - 1);
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_req_pop_q    <= w_req_pop_d;
            r_ser_data_q   <= w_ser_data_d;
            r_ser_start_q  <= w_ser_start_d;
            r_grant_id_q   <= w_grant_id_d;
            r_last_grant_q <= w_last_grant_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign req_pop   = r_req_pop_q;
    assign ser_data  = r_ser_data_q;
    assign ser_start = r_ser_start_q;
    assign grant_id  = r_grant_id_q;
    assign busy      = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx_arbiter
// Description : Self-checking bench for spi_tx_arbiter with FIFO/serializer
//               emulation and a cycle-timeline model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_spi_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_empty;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_pop;
    logic [DW-1:0]   ser_data;
    logic            ser_start;
    logic            ser_done;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    spi_tx_arbiter #(
        .NUM_REQ        (N),
        .DATAWIDTH      (DW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_empty   (req_empty),
        .req_data    (req_data),
        .req_pop     (req_pop),
        .ser_data    (ser_data),
        .ser_start   (ser_start),
        .ser_done    (ser_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            id;
        logic [DW-1:0] d;
    } item_t;

    item_t fq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    logic          t_rst = 1'b0;
    logic          t_inj = 1'b0;
    int            done_delay = 20;
    int            done_at = -1;
    int            pend_id = -1;
    logic [DW-1:0] pend_d;

    logic          m_active;
    int            m_t, m_gid, m_last;
    logic [DW-1:0] m_word, m_ser;
    logic          m_to;

    int   pop_cyc[$], pop_val[$], start_cyc[$], start_data[$], fall_cyc[$], to_cyc[$];
    logic prev_busy = 1'b0;
    int   c0;
    int   exp_rr[6] = '{1, 2, 4, 8, 1, 2};
    logic ok;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int count_of(input int id);
        int n = 0;
        foreach (fq[j]) if (fq[j].id == id) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] front_of(input int id);
        for (int j = 0; j < fq.size(); j++) if (fq[j].id == id) return fq[j].d;
        return '0;
    endfunction

    function automatic logic [DW-1:0] take(input int id);
        logic [DW-1:0] v;
        for (int j = 0; j < fq.size(); j++) begin
            if (fq[j].id == id) begin
                v = fq[j].d;
                fq.delete(j);
                return v;
            end
        end
        return '0;
    endfunction

    task automatic push(input int id, input logic [DW-1:0] d);
        item_t it;
        it.id = id;
        it.d  = d;
        fq.push_back(it);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_gid    = 0;
        m_last   = N - 1;
        m_word   = '0;
        m_ser    = '0;
        m_to     = 1'b0;
    endtask

    task automatic clear_logs();
        pop_cyc.delete(); pop_val.delete(); start_cyc.delete();
        start_data.delete(); fall_cyc.delete(); to_cyc.delete();
    endtask

    task automatic compare_outputs();
        logic [N-1:0] ep;
        int k;
        k  = cyc - m_t;
        ep = (m_active && k == 1) ? (4'b0001 << m_gid) : 4'b0000;
        chk("busy", int'(busy), int'(m_active));
        chk("req_pop", int'(req_pop), int'(ep));
        chk("ser_start", int'(ser_start), int'(m_active && k == 3));
        chk("ser_data", int'(ser_data), int'(m_ser));
        chk("grant_id", int'(grant_id), m_gid);
        chk("timeout_err", int'(timeout_err), int'(m_to));
    endtask

    task automatic log_outputs();
        if (req_pop != '0) begin
            pop_cyc.push_back(cyc);
            pop_val.push_back(int'(req_pop));
        end
        if (ser_start) begin
            start_cyc.push_back(cyc);
            start_data.push_back(int'(ser_data));
        end
        if (prev_busy && !busy) fall_cyc.push_back(cyc);
        if (timeout_err) to_cyc.push_back(cyc);
        prev_busy = busy;
    endtask

    // Emulated FIFOs present popped data one cycle after the pop; serializer answers done_delay after start.
    task automatic drive_env();
        int id;
        rst      = t_rst;
        req_data = {N{8'hEE}};
        for (int i = 0; i < N; i++) if (i == pend_id) req_data[i*DW +: DW] = pend_d;
        pend_id = -1;
        if (req_pop != '0) begin
            id = 0;
            for (int i = 0; i < N; i++) if (req_pop[i]) id = i;
            chk("pop_nonempty", int'(count_of(id) > 0), 1);
            if (count_of(id) > 0) begin
                pend_id = id;
                pend_d  = take(id);
            end
        end
        for (int i = 0; i < N; i++) req_empty[i] = (count_of(i) == 0);
        if (t_rst) done_at = -1;
        else if (ser_start && done_delay > 0) done_at = cyc + done_delay;
        ser_done = t_inj || (cyc == done_at);
    endtask

    // Timeline model: decision at m_t, pop at +1, data/start at +3, done honoured from +4.
    task automatic model_step();
        int k;
        m_to = 1'b0;
        if (t_rst) begin
            model_reset();
        end else if (m_active) begin
            k = cyc - m_t;
            if (k == 2) m_ser = m_word;
            if (k >= 4 && ser_done) begin
                m_active = 1'b0;
                m_last   = m_gid;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (k == 4 + TO - 1) begin
                m_active = 1'b0;
                m_last   = m_gid;
                m_to     = 1'b1;
            end
`endif
        end else begin
            for (int s = 1; s <= N; s++) begin
                if (!m_active && count_of((m_last + s) % N) > 0) begin
                    m_active = 1'b1;
                    m_t      = cyc;
                    m_gid    = (m_last + s) % N;
                    m_word   = front_of(m_gid);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare_outputs();
        log_outputs();
        drive_env();
        model_step();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!m_active && !busy && fq.size() == 0 && pend_id < 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic wait_start(input string nm, input int budget);
        int n0;
        n0 = start_cyc.size();
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (start_cyc.size() > n0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, int'(ok), 1);
    endtask

    initial begin
        rst       = 1'b1;
        req_empty = '1;
        req_data  = {N{8'hEE}};
        ser_done  = 1'b0;
        model_reset();

        t_rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_pop", int'(req_pop), 0);
        chk("rst_data", int'(ser_data), 0);
        chk("rst_gid", int'(grant_id), 0);
        chk("rst_start", int'(ser_start), 0);
        t_rst = 1'b0;
        tick();

        // Single word from requester 1
        clear_logs();
        push(1, 8'hA5);
        c0 = cyc + 1;
        wait_idle("sw_idle", 100);
        chk("sw_npop", pop_val.size(), 1);
        chk("sw_pop", (pop_val.size() > 0) ? pop_val[0] : -1, 4'b0010);
        chk("sw_pop_lat", (pop_cyc.size() > 0) ? pop_cyc[0] - c0 : -1, 1);
        chk("sw_start_lat", (start_cyc.size() > 0) ? start_cyc[0] - c0 : -1, 3);
        chk("sw_data", (start_data.size() > 0) ? start_data[0] : -1, 8'hA5);
        chk("sw_busy_len", (fall_cyc.size() > 0 && start_cyc.size() > 0) ? fall_cyc[0] - start_cyc[0] : -1, 21);

        // Skipping: after grant 1, only 0 and 3 pending
        clear_logs();
        push(0, 8'h10);
        push(3, 8'h30);
        wait_idle("skip_idle", 200);
        chk("skip_first", (pop_val.size() > 0) ? pop_val[0] : -1, 4'b1000);
        chk("skip_second", (pop_val.size() > 1) ? pop_val[1] : -1, 4'b0001);
        chk("done_to_pop_gap", (pop_cyc.size() > 1 && fall_cyc.size() > 0) ? pop_cyc[1] - fall_cyc[0] : -1, 1);

        // Spurious done during POP, CAPTURE, START
        clear_logs();
        push(2, 8'h22);
        c0 = cyc + 1;
        tick();
        t_inj = 1'b1;
        tick();
        tick();
        tick();
        t_inj = 1'b0;
        wait_idle("spur_idle", 100);
        chk("spur_pop", (pop_val.size() > 0) ? pop_val[0] : -1, 4'b0100);
        chk("spur_start_lat", (start_cyc.size() > 0) ? start_cyc[0] - c0 : -1, 3);
        chk("spur_busy_len", (fall_cyc.size() > 0 && start_cyc.size() > 0) ? fall_cyc[0] - start_cyc[0] : -1, 21);

        // Round-robin with all four non-empty
        t_rst = 1'b1;
        tick();
        t_rst = 1'b0;
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'((i << 4) | r));
        wait_idle("rr_idle", 600);
        chk("rr_npop", pop_val.size(), 8);
        for (int i = 0; i < 6; i++)
            chk("rr_order", (pop_val.size() > i) ? pop_val[i] : -1, exp_rr[i]);

        // Reset while in WAIT
        clear_logs();
        push(2, 8'h77);
        wait_start("mw_start", 50);
        tick();
        tick();
        push(3, 8'h33);
        push(0, 8'h0F);
        t_rst = 1'b1;
        tick();
        t_rst = 1'b0;
        tick();
        chk("mw_rst_busy", int'(busy), 0);
        chk("mw_rst_data", int'(ser_data), 0);
        chk("mw_rst_gid", int'(grant_id), 0);
        chk("mw_rst_pop", int'(req_pop), 0);
        clear_logs();
        wait_idle("mw_idle", 200);
        chk("mw_next0", (pop_val.size() > 0) ? pop_val[0] : -1, 4'b0001);
        chk("mw_next1", (pop_val.size() > 1) ? pop_val[1] : -1, 4'b1000);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: no done for the first transfer
        clear_logs();
        done_delay = 0;
        push(1, 8'h91);
        push(2, 8'h92);
        wait_start("to_start", 50);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (to_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_seen", int'(ok), 1);
        done_delay = 20;
        wait_idle("to_idle", 200);
        chk("to_lat", (to_cyc.size() > 0 && start_cyc.size() > 0) ? to_cyc[0] - start_cyc[0] : -1, 17);
        chk("to_first", (pop_val.size() > 0) ? pop_val[0] : -1, 4'b0010);
        chk("to_next", (pop_val.size() > 1) ? pop_val[1] : -1, 4'b0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin arbiter and sequencer that shares one `spi_serializer` among `NUM_REQ` transmit FIFOs. It watches each FIFO's empty flag, pops one word from the granted FIFO, and loads it into the serializer. It then waits for the serializer's `done` before granting again. It sits between the per-source FIFO read ports and the serializer's `read_data`/`full` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesting FIFOs, 1..16.
- `DATAWIDTH`, default `` `DATA_WIDTH ``: word width; must match the serializer.
- `TIMEOUT_CYCLES`, default 1024: WAIT-state watchdog limit; used only with `SPI_ARB_TIMEOUT_EN`.
- `GIDW`, default `$clog2(NUM_REQ)` with a minimum of 1: grant index width.

Ports (clock and reset first):
- `clk  in  1`: single clock; everything is on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_empty  in  NUM_REQ`: FIFO empty flags; bit i belongs to requester i.
- `req_data  in  NUM_REQ*DATAWIDTH`: flattened FIFO read data; slice i is `[i*DATAWIDTH +: DATAWIDTH]`. Data is valid the cycle after the pop.
- `req_pop  out  NUM_REQ`: one-hot, one-cycle read strobe.
- `ser_data  out  DATAWIDTH`: registered word; drives the serializer's `read_data`.
- `ser_start  out  1`: one-cycle load strobe; drives the serializer's `full`.
- `ser_done  in  1`: serializer transfer-complete pulse.
- `grant_id  out  GIDW`: index of the current or last granted requester.
- `busy  out  1`: high in every state except IDLE.
- `timeout_err  out  1`: one-cycle watchdog pulse; tied to 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, POP, CAPTURE, START, WAIT.
- **IDLE:**
  - If `~req_empty` is nonzero, pick the first non-empty requester scanning upward from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - Register the pick into `grant_id` and go to POP.
  - Otherwise stay in IDLE.
- **POP:** `req_pop[grant_id]=1` for this cycle only; go to CAPTURE.
- **CAPTURE:** latch `req_data` slice `grant_id` into `ser_data`; go to START.
- **START:** `ser_start=1` for this cycle only, with `ser_data` stable; go to WAIT.
- **WAIT:**
  - Hold `ser_data`.
  - On `ser_done=1`: set `last_grant <= grant_id` and go to IDLE.
- `ser_done` is ignored in every state except WAIT.
- Only this block pops the FIFOs, so a grant never targets an empty FIFO. `req_empty` changes after the IDLE decision do not cancel a grant.
- With `NUM_REQ=1`, requester 0 is always the pick.

## Timing
- **Reset values:**
  - State IDLE.
  - `req_pop=0`, `ser_start=0`, `ser_data=0`, `grant_id=0`, `busy=0`, `timeout_err=0`.
  - `last_grant=NUM_REQ-1`, so the first grant goes to requester 0.
- All outputs are registered.
- Latency, with the decision in IDLE at cycle t:
  - `req_pop` at t+1.
  - `ser_data` valid at t+3.
  - `ser_start` at t+3.
- IDLE is re-entered the cycle after `ser_done`. The next pop comes one cycle after that at the earliest, giving a minimum 2-cycle gap between a done and the next `req_pop`.
- **Reset mid-operation:** immediate return to IDLE with the reset values. The popped word is discarded. The serializer shares `rst`.
- **Fairness:** with all requesters non-empty, grants rotate 0,1,…,NUM_REQ-1,0,…

## Configuration
- **`SPI_ARB_TIMEOUT_EN` defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES)+1` clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `ser_done`: `timeout_err=1` for one cycle, go to IDLE, update `last_grant`, drop the word.
  - A `ser_done` in the same cycle as the limit wins: normal completion, no error.
- **Not defined:**
  - No counter.
  - WAIT blocks indefinitely.
  - `timeout_err` is constant 0.

## Structure
- `spi_defines_pkg` gains:
  - the `arb_state_t` enum (IDLE, POP, CAPTURE, START, WAIT);
  - `ARB_NUM_REQ` as the default constant;
  - `ARB_TIMEOUT_CYCLES` as the default constant.
- One sub-module, `spi_rr_picker`, a combinational round-robin pick with:
  - inputs: request vector and `last_grant`;
  - outputs: `pick_valid` and `pick_id`.
- The FSM, datapath register and watchdog live in `spi_tx_arbiter`.

## Test plan
- **Single word:** reset, then `req_empty=4'b1101` and slice1=`8'hA5` (valid after pop). Expect:
  - `req_pop=4'b0010` once;
  - `ser_data=8'hA5` and `ser_start` 3 cycles after the IDLE decision;
  - `busy` held until `ser_done`.
- **Round-robin:** all four FIFOs non-empty, done returned 20 cycles after each start. Expect grant order 0,1,2,3,0,1 with exactly one pop per grant.
- **Skipping:** after a grant to 1, only requesters 0 and 3 non-empty. Expect next grant 3, then 0.
- **Spurious done:** pulse `ser_done` during POP, CAPTURE and START. Expect no state change; WAIT still requires a real done.
- **Reset mid-WAIT:** assert `rst` for one cycle in WAIT. Expect all outputs at reset values the next cycle, and the next grant to requester 0.
- **`SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`:** never return done. Expect:
  - a `timeout_err` pulse 16 cycles after entering WAIT;
  - return to IDLE;
  - the next grant to the following requester.
